pattern_tx: RTL and testbench
=============================

PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, meaning the serial pattern length in bits (legal range 2..16).
REQ-002 The block SHALL have parameter PATTERN, default 5'b10010, meaning the built-in pattern, transmitted MSB first.
REQ-003 The block SHALL have parameter GAP, default 2, meaning the number of idle cycles between repetitions (legal range 0..15).
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  request to begin a burst; sampled only in IDLE.
REQ-007 use_ext  input  1  1 = transmit pat_in, 0 = transmit PATTERN; sampled with start.
REQ-008 pat_in  input  WIDTH  external pattern, MSB sent first; sampled with start.
REQ-009 reps  input  4  repetition count; sampled with start; 0 is treated as 1.
REQ-010 abort  input  1  synchronous cancel of the burst in progress.
REQ-011 j  output  1  serial data bit, drives a downstream detector's j input.
REQ-012 valid  output  1  high when j carries a pattern bit.
REQ-013 frame_last  output  1  high with the last bit of each repetition.
REQ-014 busy  output  1  high in SEND and GAP states.
REQ-015 done  output  1  one-cycle pulse when a burst completes normally.

Function
REQ-016 The block SHALL be a Moore FSM with states IDLE, SEND, GAP and DONE; every output SHALL be a function of registered state only, with no input-to-output combinational path.
REQ-017 In IDLE, start=1 at a rising edge SHALL capture the pattern (pat_in or PATTERN per use_ext) into a shift register, load the rep counter with max(reps,1), set bit index WIDTH-1, and enter SEND.
REQ-018 In SEND, j SHALL equal the captured bit at the current index and valid SHALL be 1; the index SHALL decrement by one each cycle (one bit per clock).
REQ-019 The first bit SHALL appear in the cycle immediately after the edge that sampled start (latency 1).
REQ-020 frame_last SHALL be 1 in SEND only when index=0.
REQ-021 At index=0 with reps remaining >1, the rep counter SHALL decrement; the FSM SHALL enter GAP if GAP>0, or re-enter SEND at index WIDTH-1 directly if GAP=0 (back-to-back frames).
REQ-022 At index=0 with reps remaining =1, the FSM SHALL enter DONE.
REQ-023 In GAP, j=0 and valid=0 for exactly GAP cycles; the FSM SHALL then enter SEND at index WIDTH-1.
REQ-024 DONE SHALL last exactly one cycle with done=1 and busy=0, then return to IDLE.
REQ-025 A burst SHALL occupy exactly R*WIDTH + (R-1)*GAP busy cycles, where R=max(reps,1).
REQ-026 start SHALL be ignored in SEND, GAP and DONE; pat_in, use_ext and reps changes SHALL have no effect after capture.
REQ-027 abort=1 in SEND or GAP SHALL force IDLE at the next edge with done not pulsed; abort in IDLE or DONE SHALL have no effect.
REQ-028 If abort=1 and start=1 in the same IDLE cycle, start SHALL win and the burst SHALL begin.
REQ-029 In IDLE, j, valid, frame_last, busy and done SHALL all be 0.
REQ-030 Undefined state encodings SHALL recover to IDLE on the next edge.

Reset
REQ-031 rst=1 SHALL immediately, without a clock edge, force IDLE, clear all counters and the shift register, and drive j, valid, frame_last, busy and done to 0.
REQ-032 rst asserted mid-burst SHALL abandon the burst; after release, the FSM SHALL stay in IDLE until a new start.

Verification
REQ-033 Scenario: use_ext=0, reps=1, start pulse -> j=1,0,0,1,0 with valid=1 on 5 consecutive cycles, frame_last on the 5th bit, done on cycle 6, busy for 5 cycles.
REQ-034 Scenario: use_ext=1, pat_in=5'b11001, reps=3, GAP=2 -> 3 frames 11001 separated by 2 cycles of j=0/valid=0, busy for 19 cycles, one done pulse.
REQ-035 Scenario: reps=0 -> identical to reps=1; GAP=0 with reps=2 -> 10 contiguous valid bits 1001010010.
REQ-036 Scenario: abort asserted on the 3rd bit of frame 2 -> next cycle IDLE with all outputs 0 and no done; start held high throughout an active burst -> exactly one burst.
REQ-037 Scenario: rst pulsed mid-GAP -> outputs 0 asynchronously; after release, a new start transmits a fresh 10010.
REQ-038 Scenario: j/valid looped into a 10010 Moore detector, reps=2, GAP=0 -> detector output asserts once per frame boundary as expected for the overlapping stream.

Source files
------------

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: sends a built-in or captured pattern MSB first,
// repeated with idle gaps, as a Moore FSM with registered-state outputs.
module pattern_tx #(
  parameter int              WIDTH   = 5,
  parameter logic [WIDTH-1:0] PATTERN = 5'b10010,
  parameter int              GAP     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             use_ext,
  input  logic [WIDTH-1:0] pat_in,
  input  logic [3:0]       reps,
  input  logic             abort,
  output logic             j,
  output logic             valid,
  output logic             frame_last,
  output logic             busy,
  output logic             done
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);
  localparam logic [3:0] GAP_LD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [3:0]       rep_q, rep_d;
  logic [3:0]       gap_q, gap_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          shreg_d = use_ext ? pat_in : PATTERN;
          rep_d   = (reps == 4'd0) ? 4'd1 : reps;
          idx_d   = LAST;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (idx_q != '0) begin
          idx_d = idx_q - 1'b1;
        end else if (rep_q > 4'd1) begin
          rep_d = rep_q - 4'd1;
          idx_d = LAST;
          // With no gap, the next frame follows back-to-back
          if (GAP > 0) begin
            state_d = S_GAP;
            gap_d   = GAP_LD;
          end
        end else begin
          state_d = S_DONE;
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (gap_q == 4'd0) begin
          state_d = S_SEND;
          idx_d   = LAST;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign valid      = (state_q == S_SEND);
  assign j          = valid & shreg_q[idx_q];
  assign frame_last = valid & (idx_q == '0);
  assign busy       = (state_q == S_SEND) | (state_q == S_GAP);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_pattern_tx.sv
// Randomized bench for pattern_tx: per-cycle output words from a frame-level
// model, plus reset, abort, gap-less and detector-stream scenarios.
module tb_pattern_tx;

  logic       clk = 1'b0;
  logic       rst, start1, start2, use_ext, abort;
  logic [4:0] pat_in;
  logic [3:0] reps;
  logic j1, v1, fl1, b1, d1;
  logic j2, v2, fl2, b2, d2;
  int total = 0;
  int bad = 0;
  int det;

  always #5 clk = ~clk;

  pattern_tx #(.WIDTH(5), .PATTERN(5'b10010), .GAP(2)) u_dut (
    .clk(clk), .rst(rst), .start(start1), .use_ext(use_ext),
    .pat_in(pat_in), .reps(reps), .abort(abort),
    .j(j1), .valid(v1), .frame_last(fl1), .busy(b1), .done(d1)
  );

  pattern_tx #(.WIDTH(5), .PATTERN(5'b10010), .GAP(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start2), .use_ext(use_ext),
    .pat_in(pat_in), .reps(reps), .abort(abort),
    .j(j2), .valid(v2), .frame_last(fl2), .busy(b2), .done(d2)
  );

  function automatic logic [4:0] obs(input bit sel);
    return sel ? {j2, v2, fl2, b2, d2} : {j1, v1, fl1, b1, d1};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) start2 = v;
    else start1 = v;
  endtask

  // Word layout: {j, valid, frame_last, busy, done}
  task automatic burst(input bit sel, input bit ext, input logic [4:0] p,
                       input logic [3:0] rp, input int abort_at,
                       input bit ab_start, output int ndet);
    logic [4:0] q[$];
    logic [4:0] pat, w, o;
    int r_n, g, nb, nd, nv;
    pat = ext ? p : 5'b10010;
    r_n = (rp == 0) ? 1 : int'(rp);
    g = sel ? 0 : 2;
    for (int r = 0; r < r_n; r++) begin
      for (int b = 4; b >= 0; b--)
        q.push_back({pat[b], 1'b1, b == 0, 1'b1, 1'b0});
      if (r < r_n - 1)
        for (int k = 0; k < g; k++) q.push_back(5'b00010);
    end
    q.push_back(5'b00001);
    nb = 0; nd = 0; nv = 0; ndet = 0; w = '0;
    use_ext = ext; pat_in = p; reps = rp; abort = ab_start;
    set_start(sel, 1'b1);
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk); #1;
      o = obs(sel);
      chk($sformatf("cyc%0d", i), o, q[i]);
      nb += o[1]; nd += o[0];
      if (o[3]) begin
        w = {w[3:0], o[4]}; nv++;
        if (nv >= 5 && w == 5'b10010) ndet++;
      end
      if (i == abort_at) begin
        abort = 1'b1; set_start(sel, 1'b0);
        @(posedge clk); #1;
        chk("abort_idle", obs(sel), 5'b0);
        abort = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          chk("abort_nodone", obs(sel), 5'b0);
        end
        return;
      end
      set_start(sel, 1'($urandom));
      use_ext = 1'($urandom); pat_in = 5'($urandom);
      reps = 4'($urandom); abort = 1'b0;
    end
    set_start(sel, 1'b0);
    chk("busy_len", nb, r_n * 5 + (r_n - 1) * g);
    chk("done_cnt", nd, 1);
    repeat (2) begin
      @(posedge clk); #1;
      chk("idle_after", obs(sel), 5'b0);
    end
  endtask

  initial begin
    rst = 1'b1; start1 = 0; start2 = 0; use_ext = 0; abort = 0;
    pat_in = '0; reps = '0;
    #3;
    chk("rst_a", obs(0), 5'b0);
    chk("rst_b", obs(1), 5'b0);
    #9 rst = 1'b0;
    @(posedge clk); #1;
    chk("idle0", obs(0), 5'b0);

    burst(0, 0, 5'($urandom), 4'd1, -1, 0, det);
    burst(0, 1, 5'b11001, 4'd3, -1, 0, det);
    burst(0, 0, 5'($urandom), 4'd0, -1, 0, det);
    burst(1, 0, 5'($urandom), 4'd2, -1, 0, det);
    chk("detect", det, 2);
    burst(0, 1, 5'($urandom), 4'd3, 9, 0, det);
    burst(0, 0, 5'($urandom), 4'd2, -1, 1, det);

    for (int k = 0; k < 8; k++)
      burst(k[0], 1'($urandom), 5'($urandom),
            4'($urandom_range(0, 4)), -1, 0, det);
    burst(1, 1, 5'($urandom), 4'd3, 7, 0, det);

    use_ext = 0; reps = 4'd3; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("in_gap", obs(0), 5'b00010);
    #2 rst = 1'b1;
    #1;
    chk("rst_async", obs(0), 5'b0);
    #10 rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_idle", obs(0), 5'b0);
    end
    burst(0, 0, 5'($urandom), 4'd1, -1, 0, det);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
